// File: rtl/p4_router_egress_sched.sv
// Packet-granular round-robin egress scheduler with a beat-limit check and a stall watchdog.
// Optional per-port grant/beat statistics are enabled by defining P4_ROUTER_EGR_SCHED_STATS_EN.
module p4_router_egress_sched #(
  parameter int NUM_EGR_PHYS_PORTS   = 4,
  parameter int EGR_BUS_DATA_BYTES   = 64,
  parameter int MTU_BYTES            = 1500,
  parameter int STALL_TIMEOUT_CYCLES = 1024,
  parameter int EGR_COUNTERS_WIDTH   = 32
) (
  input  logic                                  clk,
  input  logic                                  areset,
  input  logic [NUM_EGR_PHYS_PORTS-1:0]         queue_nonempty,
  input  logic [NUM_EGR_PHYS_PORTS-1:0]         egr_buf_ready,
  input  logic [NUM_EGR_PHYS_PORTS-1:0]         egr_phys_ports_enable,
  output logic                                  deq_valid,
  output logic [$clog2(NUM_EGR_PHYS_PORTS)-1:0] deq_port,
  input  logic                                  deq_ready,
  input  logic                                  egr_tvalid,
  input  logic                                  egr_tlast,
  output logic                                  sched_busy,
  output logic [1:0]                            sched_err,
`ifdef P4_ROUTER_EGR_SCHED_STATS_EN
  output logic [EGR_COUNTERS_WIDTH-1:0]         grant_cnts [NUM_EGR_PHYS_PORTS],
  output logic [EGR_COUNTERS_WIDTH-1:0]         beat_cnts  [NUM_EGR_PHYS_PORTS],
  input  logic [NUM_EGR_PHYS_PORTS-1:0]         stats_clear,
`endif
  input  logic                                  sched_err_clear
);

  localparam int PW            = $clog2(NUM_EGR_PHYS_PORTS);
  localparam int MAX_PKT_BEATS = (MTU_BYTES + EGR_BUS_DATA_BYTES - 1) / EGR_BUS_DATA_BYTES;
  localparam int BW            = $clog2(MAX_PKT_BEATS + 1);
  localparam int SW            = $clog2(STALL_TIMEOUT_CYCLES + 1);

  localparam logic [BW-1:0] BEAT_LAST  = BW'(MAX_PKT_BEATS - 1);
  localparam logic [BW-1:0] BEAT_MAX   = BW'(MAX_PKT_BEATS);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t                  state;
  logic [PW-1:0]           ptr;
  logic [BW-1:0]           beat_cnt;
  logic [SW-1:0]           stall_cnt;
  logic [NUM_EGR_PHYS_PORTS-1:0] elig;
  logic                    sel_found;
  logic [PW-1:0]           sel_port;

  assign elig = queue_nonempty & egr_buf_ready & egr_phys_ports_enable;

  // Round-robin search starting just after the last granted port.
  always_comb begin
    int idx;
    sel_found = 1'b0;
    sel_port  = '0;
    idx       = 0;
    for (int i = 1; i <= NUM_EGR_PHYS_PORTS; i++) begin
      idx = (int'(ptr) + i) % NUM_EGR_PHYS_PORTS;
      if (!sel_found && elig[PW'(idx)]) begin
        sel_found = 1'b1;
        sel_port  = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state      <= IDLE;
      deq_valid  <= 1'b0;
      deq_port   <= '0;
      sched_busy <= 1'b0;
      sched_err  <= '0;
      ptr        <= PW'(NUM_EGR_PHYS_PORTS - 1);
      beat_cnt   <= '0;
      stall_cnt  <= '0;
    end else begin
      // Error sets below are scheduled later, so a same-cycle set beats the clear.
      if (sched_err_clear) sched_err <= '0;
      case (state)
        IDLE: begin
          if (sel_found) begin
            deq_port   <= sel_port;
            deq_valid  <= 1'b1;
            sched_busy <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (deq_ready) begin
            deq_valid <= 1'b0;
            ptr       <= deq_port;
            beat_cnt  <= '0;
            stall_cnt <= '0;
            state     <= XFER;
          end
        end
        XFER: begin
          if (egr_tvalid) begin
            stall_cnt <= '0;
            if (beat_cnt != BEAT_MAX) beat_cnt <= beat_cnt + 1'b1;
            if (egr_tlast) begin
              state      <= IDLE;
              sched_busy <= 1'b0;
            end else if (beat_cnt == BEAT_LAST) begin
              sched_err[0] <= 1'b1;
              state        <= IDLE;
              sched_busy   <= 1'b0;
            end
          end else if (stall_cnt == STALL_LAST) begin
            sched_err[1] <= 1'b1;
            state        <= IDLE;
            sched_busy   <= 1'b0;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          deq_valid  <= 1'b0;
          sched_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef P4_ROUTER_EGR_SCHED_STATS_EN
  logic grant_fire;
  logic beat_fire;

  assign grant_fire = (state == REQ) && deq_valid && deq_ready;
  assign beat_fire  = (state == XFER) && egr_tvalid;

  // deq_port stays frozen through XFER, so it also attributes beats to their port.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_EGR_PHYS_PORTS; i++) begin
        grant_cnts[i] <= '0;
        beat_cnts[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_EGR_PHYS_PORTS; i++) begin
        if (stats_clear[i]) begin
          grant_cnts[i] <= '0;
          beat_cnts[i]  <= '0;
        end else begin
          if (grant_fire && (deq_port == PW'(i)) && !(&grant_cnts[i]))
            grant_cnts[i] <= grant_cnts[i] + 1'b1;
          if (beat_fire && (deq_port == PW'(i)) && !(&beat_cnts[i]))
            beat_cnts[i] <= beat_cnts[i] + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_p4_router_egress_sched.sv
// Self-checking bench for p4_router_egress_sched: vector table, directed corner cases and a
// randomized run against a transaction-level reference model.
module tb_p4_router_egress_sched;

  localparam int N    = 4;
  localparam int PW   = 2;
  localparam int TO   = 16;
  localparam int MAXB = 24;

  logic          clk = 1'b0;
  logic          areset;
  logic [N-1:0]  queue_nonempty;
  logic [N-1:0]  egr_buf_ready;
  logic [N-1:0]  egr_phys_ports_enable;
  logic          deq_valid;
  logic [PW-1:0] deq_port;
  logic          deq_ready;
  logic          egr_tvalid;
  logic          egr_tlast;
  logic          sched_busy;
  logic [1:0]    sched_err;
  logic          sched_err_clear;
`ifdef P4_ROUTER_EGR_SCHED_STATS_EN
  logic [31:0]   grant_cnts [N];
  logic [31:0]   beat_cnts  [N];
  logic [N-1:0]  stats_clear;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  p4_router_egress_sched #(
    .NUM_EGR_PHYS_PORTS  (N),
    .EGR_BUS_DATA_BYTES  (64),
    .MTU_BYTES           (1500),
    .STALL_TIMEOUT_CYCLES(TO),
    .EGR_COUNTERS_WIDTH  (32)
  ) dut (
    .clk                  (clk),
    .areset               (areset),
    .queue_nonempty       (queue_nonempty),
    .egr_buf_ready        (egr_buf_ready),
    .egr_phys_ports_enable(egr_phys_ports_enable),
    .deq_valid            (deq_valid),
    .deq_port             (deq_port),
    .deq_ready            (deq_ready),
    .egr_tvalid           (egr_tvalid),
    .egr_tlast            (egr_tlast),
    .sched_busy           (sched_busy),
    .sched_err            (sched_err),
`ifdef P4_ROUTER_EGR_SCHED_STATS_EN
    .grant_cnts           (grant_cnts),
    .beat_cnts            (beat_cnts),
    .stats_clear          (stats_clear),
`endif
    .sched_err_clear      (sched_err_clear)
  );

  typedef struct {
    logic [N-1:0]  q;
    logic [N-1:0]  b;
    logic [N-1:0]  e;
    logic          exp_valid;
    logic [PW-1:0] exp_port;
  } vec_t;

  vec_t vecs [12];

  // Reference model state: phase 0 waiting, 1 requesting, 2 transferring.
  int         m_phase;
  int         m_ptr;
  int         m_port;
  int         m_beats;
  int         m_idle;
  logic       m_valid;
  logic [1:0] m_err;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] q, input logic [N-1:0] b, input logic [N-1:0] e,
                               input logic rdy, input logic tv, input logic tl);
    queue_nonempty        = q;
    egr_buf_ready         = b;
    egr_phys_ports_enable = e;
    deq_ready             = rdy;
    egr_tvalid            = tv;
    egr_tlast             = tl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    areset = 1'b1;
    applyStimulus('0, '0, '0, 1'b0, 1'b0, 1'b0);
    sched_err_clear = 1'b0;
`ifdef P4_ROUTER_EGR_SCHED_STATS_EN
    stats_clear = '0;
`endif
    repeat (2) @(posedge clk);
    #1 areset = 1'b0;
    #1;
  endtask

  function automatic int rrPick(input int ptr, input logic [N-1:0] elig);
    for (int k = 1; k <= N; k++) begin
      int p;
      p = (ptr + k) % N;
      if (elig[p]) return p;
    end
    return -1;
  endfunction

  task automatic modelInit();
    m_phase = 0;
    m_ptr   = N - 1;
    m_port  = 0;
    m_beats = 0;
    m_idle  = 0;
    m_valid = 1'b0;
    m_err   = 2'b00;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelStep();
    logic [N-1:0] elig;
    logic [1:0]   err_n;
    int           p;
    elig  = queue_nonempty & egr_buf_ready & egr_phys_ports_enable;
    err_n = sched_err_clear ? 2'b00 : m_err;
    if (m_phase == 0) begin
      p = rrPick(m_ptr, elig);
      if (p >= 0) begin
        m_port  = p;
        m_valid = 1'b1;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (deq_ready) begin
        m_valid = 1'b0;
        m_ptr   = m_port;
        m_beats = 0;
        m_idle  = 0;
        m_phase = 2;
      end
    end else begin
      if (egr_tvalid) begin
        m_beats++;
        m_idle = 0;
        if (egr_tlast) m_phase = 0;
        else if (m_beats == MAXB) begin
          err_n[0] = 1'b1;
          m_phase  = 0;
        end
      end else begin
        m_idle++;
        if (m_idle == TO) begin
          err_n[1] = 1'b1;
          m_phase  = 0;
        end
      end
    end
    m_err = err_n;
  endtask

  initial begin
    logic slow;

    vecs[0]  = '{4'hF, 4'hF, 4'hF, 1'b1, 2'd0};
    vecs[1]  = '{4'hF, 4'hF, 4'hF, 1'b1, 2'd1};
    vecs[2]  = '{4'hF, 4'hF, 4'hF, 1'b1, 2'd2};
    vecs[3]  = '{4'hF, 4'hF, 4'hF, 1'b1, 2'd3};
    vecs[4]  = '{4'hF, 4'hF, 4'hF, 1'b1, 2'd0};
    vecs[5]  = '{4'hA, 4'hF, 4'hF, 1'b1, 2'd1};
    vecs[6]  = '{4'hA, 4'hF, 4'hF, 1'b1, 2'd3};
    vecs[7]  = '{4'hA, 4'hF, 4'hF, 1'b1, 2'd1};
    vecs[8]  = '{4'hA, 4'h7, 4'hF, 1'b1, 2'd1};
    vecs[9]  = '{4'hA, 4'h7, 4'hD, 1'b0, 2'd0};
    vecs[10] = '{4'h1, 4'hF, 4'hF, 1'b1, 2'd0};
    vecs[11] = '{4'h4, 4'hF, 4'hF, 1'b1, 2'd2};

    doReset();
    checkOutput("reset_valid", deq_valid, 0);
    checkOutput("reset_port", deq_port, 0);
    checkOutput("reset_busy", sched_busy, 0);
    checkOutput("reset_err", sched_err, 0);

    // Arbitration vectors: one single-beat packet per granted record.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].q, vecs[i].b, vecs[i].e, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput($sformatf("vec%0d_valid", i), deq_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        checkOutput($sformatf("vec%0d_port", i), deq_port, vecs[i].exp_port);
        applyStimulus('0, '0, '0, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus('0, '0, '0, 1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus('0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
      end
    end

    // Fairness with back-to-back 3-beat packets and the 2-cycle re-grant gap.
    doReset();
    applyStimulus(4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("rr%0d_valid", k), deq_valid, 1);
      checkOutput($sformatf("rr%0d_port", k), deq_port, k % N);
      tick();
      egr_tvalid = 1'b1;
      egr_tlast  = 1'b0;
      tick();
      tick();
      egr_tlast = 1'b1;
      tick();
      egr_tvalid = 1'b0;
      egr_tlast  = 1'b0;
      checkOutput($sformatf("rr%0d_gap", k), deq_valid, 0);
      tick();
    end

    // Request must hold while deq_ready is low even though the queue empties.
    doReset();
    applyStimulus(4'h4, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
    tick();
    queue_nonempty = '0;
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("hold%0d_valid", k), deq_valid, 1);
      checkOutput($sformatf("hold%0d_port", k), deq_port, 2);
      tick();
    end
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    checkOutput("hold_done_valid", deq_valid, 0);
    checkOutput("hold_done_busy", sched_busy, 1);

    // Overrun: 25 beats without tlast.
    egr_tvalid = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (k == 23) begin
        checkOutput("ovr_b23_err", sched_err, 0);
        checkOutput("ovr_b23_busy", sched_busy, 1);
      end
      if (k == 24) begin
        checkOutput("ovr_b24_err", sched_err, 1);
        checkOutput("ovr_b24_busy", sched_busy, 0);
      end
    end
    egr_tvalid = 1'b0;
    checkOutput("ovr_sticky_err", sched_err, 1);
    checkOutput("ovr_idle_busy", sched_busy, 0);
    sched_err_clear = 1'b1;
    tick();
    sched_err_clear = 1'b0;
    checkOutput("ovr_clear_err", sched_err, 0);

    // Stall watchdog after a handshake with no beats.
    applyStimulus(4'h1, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("stall_grant_port", deq_port, 0);
    queue_nonempty = '0;
    tick();
    deq_ready = 1'b0;
    repeat (TO - 1) tick();
    checkOutput("stall_pre_err", sched_err, 0);
    checkOutput("stall_pre_busy", sched_busy, 1);
    tick();
    checkOutput("stall_err", sched_err, 2);
    checkOutput("stall_busy", sched_busy, 0);
    queue_nonempty = 4'h8;
    tick();
    checkOutput("stall_resume_valid", deq_valid, 1);
    checkOutput("stall_resume_port", deq_port, 3);

    // Asynchronous reset in the middle of a transfer.
    deq_ready = 1'b1;
    tick();
    deq_ready  = 1'b0;
    egr_tvalid = 1'b1;
    tick();
    #2 areset = 1'b1;
    #1;
    checkOutput("areset_busy", sched_busy, 0);
    checkOutput("areset_valid", deq_valid, 0);
    checkOutput("areset_err", sched_err, 0);
`ifdef P4_ROUTER_EGR_SCHED_STATS_EN
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("areset_grant_cnt%0d", i), grant_cnts[i], 0);
      checkOutput($sformatf("areset_beat_cnt%0d", i), beat_cnts[i], 0);
    end
`endif
    @(negedge clk);
    areset = 1'b0;
    applyStimulus(4'h6, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("post_reset_valid", deq_valid, 1);
    checkOutput("post_reset_port", deq_port, 1);

    // Randomized traffic against the reference model, alternating busy and sparse beat phases.
    doReset();
    modelInit();
    for (int c = 0; c < 3000; c++) begin
      slow = ((c / 250) % 2) == 1;
      applyStimulus(N'($urandom),
                    ($urandom_range(0, 3) != 0) ? 4'hF : N'($urandom),
                    ($urandom_range(0, 3) != 0) ? 4'hF : N'($urandom),
                    $urandom_range(0, 2) != 0,
                    slow ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 4) < 3),
                    $urandom_range(0, 9) == 0);
      sched_err_clear = ($urandom_range(0, 31) == 0);
      modelStep();
      tick();
      checkOutput($sformatf("rand%0d_valid", c), deq_valid, m_valid);
      checkOutput($sformatf("rand%0d_port", c), deq_port, m_port);
      checkOutput($sformatf("rand%0d_busy", c), sched_busy, m_phase != 0);
      checkOutput($sformatf("rand%0d_err", c), sched_err, m_err);
    end
    sched_err_clear = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
